// File: rtl/nv_blkbox_src_gen_pkg.sv
// ----------------------------------------------------------------------------
// nv_blkbox_src_pkg
// Shared types and constants for the blackbox pattern source.
//   src_mode_e  : per-channel pattern selector (CONST / INCR / LFSR / WALK1)
//   src_state_e : burst controller states (IDLE / RUN / DONE)
//   SRC_LFSR_TAPS_DFLT : default Galois tap mask for 8-bit lanes
// ----------------------------------------------------------------------------
package nv_blkbox_src_pkg;

    typedef enum logic [1:0] {
        SRC_CONST = 2'd0,
        SRC_INCR  = 2'd1,
        SRC_LFSR  = 2'd2,
        SRC_WALK1 = 2'd3
    } src_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } src_state_e;

    localparam logic [7:0] SRC_LFSR_TAPS_DFLT = 8'hB8;

endpackage

// File: rtl/nv_blkbox_src_gen_if.sv
// ----------------------------------------------------------------------------
// nv_blkbox_src_gen_if
// Valid/ready pattern stream leaving the blackbox source.
//   dout       : NCH lanes of DW bits, lane c at [DW*c +: DW]
//   dout_valid : beat valid (driven by the source)
//   dout_ready : downstream accept (driven by the sink)
// master modport = source side, slave modport = sink side.
// ----------------------------------------------------------------------------
interface nv_blkbox_src_gen_if #(
    parameter int DW  = 8,
    parameter int NCH = 4
);

    logic [NCH*DW-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );

endinterface

// File: rtl/nv_blkbox_src_gen_lane.sv
// ----------------------------------------------------------------------------
// nv_blkbox_src_lane
// One channel's pattern register.
//   clk, rst : clock and synchronous active-high reset
//   clear    : force the lane back to zero (end of burst / abort)
//   load     : capture mode and seed, present the first beat
//   advance  : step to the next pattern value (beat accepted)
//   mode     : pattern selector, sampled on load only
//   seed     : constant / seed value, sampled on load only
//   value    : registered lane output
// Priority when several controls are high: clear > load > advance.
// ----------------------------------------------------------------------------
module nv_blkbox_src_lane
    import nv_blkbox_src_pkg::*;
#(
    parameter int              DW        = 8,
    parameter logic [DW-1:0]   LFSR_TAPS = DW'(SRC_LFSR_TAPS_DFLT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          load,
    input  logic          advance,
    input  src_mode_e     mode,
    input  logic [DW-1:0] seed,
    output logic [DW-1:0] value
);

    localparam logic [DW-1:0] ONE    = {{(DW-1){1'b0}}, 1'b1};
    // DW always fits in DW bits, so the modulus can stay lane-width
    localparam logic [DW-1:0] DW_MOD = DW'(DW);

    src_mode_e     mode_q,  mode_d;
    logic [DW-1:0] value_q, value_d;
    logic [DW-1:0] first_val;
    logic [DW-1:0] next_val;
    logic [DW-1:0] walk_pos;

    // First beat of a burst, derived from the live seed at load time.
    // LFSR never starts in the all-zero lock-up state.
    always_comb begin
        walk_pos = seed % DW_MOD;
        case (mode)
            SRC_LFSR:  first_val = (seed == '0) ? ONE : seed;
            SRC_WALK1: first_val = ONE << walk_pos;
            default:   first_val = seed;
        endcase
    end

    // Next value after an accepted beat, using the mode captured at load.
    always_comb begin
        case (mode_q)
            SRC_INCR:  next_val = value_q + ONE;
            SRC_LFSR:  next_val = value_q[0] ? ((value_q >> 1) ^ LFSR_TAPS)
                                             : (value_q >> 1);
            SRC_WALK1: next_val = {value_q[DW-2:0], value_q[DW-1]};
            default:   next_val = value_q;
        endcase
    end

    always_comb begin
        mode_d  = mode_q;
        value_d = value_q;
        if (clear) begin
            mode_d  = SRC_CONST;
            value_d = '0;
        end else if (load) begin
            mode_d  = mode;
            value_d = first_val;
        end else if (advance) begin
            value_d = next_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= SRC_CONST;
            value_q <= '0;
        end else begin
            mode_q  <= mode_d;
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/nv_blkbox_src_gen.sv
// ----------------------------------------------------------------------------
// nv_blkbox_src_gen
// Multi-channel tie-off / stimulus source. Drives zero while idle; a start
// pulse launches a burst of cfg_len+1 beats of per-channel patterns on a
// valid/ready stream.
//   nvdla_core_clk, nvdla_core_rst : clock, synchronous active-high reset
//   cfg_mode  : per-channel mode, channel c at [2c+1:2c]
//   cfg_value : per-channel seed/constant, channel c at [DW*c +: DW]
//   cfg_len   : burst length minus one
//   start     : burst request (honoured in IDLE only)
//   abort     : drop the active burst without a done pulse
//   src       : dout / dout_valid / dout_ready stream (master side)
//   busy      : high while a burst is running
//   done      : one-cycle pulse after a normally completed burst
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module nv_blkbox_src_gen
    import nv_blkbox_src_pkg::*;
#(
    parameter int            DW        = 8,
    parameter int            NCH       = 4,
    parameter int            LENW      = 8,
    parameter logic [DW-1:0] LFSR_TAPS = DW'(SRC_LFSR_TAPS_DFLT)
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rst,
    input  logic [NCH*2-1:0]     cfg_mode,
    input  logic [NCH*DW-1:0]    cfg_value,
    input  logic [LENW-1:0]      cfg_len,
    input  logic                 start,
    input  logic                 abort,
    nv_blkbox_src_gen_if.master  src,
    output logic                 busy,
    output logic                 done
);

    src_state_e        state_q, state_d;
    logic [LENW-1:0]   cnt_q,   cnt_d;
    logic [LENW-1:0]   len_q,   len_d;
    logic              valid_q, valid_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic              lane_clear;
    logic              lane_load;
    logic              lane_advance;
    logic              accept;
    logic [NCH*DW-1:0] lane_dout;

    assign accept = valid_q & src.dout_ready;

    // Burst controller. Output flags are computed for the next state so they
    // can be registered alongside it. Abort is checked before the final
    // accept so that it wins when both land in the same cycle; leaving RUN by
    // either path clears the lanes so dout reads zero from the next cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        valid_d      = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        lane_clear   = 1'b0;
        lane_load    = 1'b0;
        lane_advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    lane_load = 1'b1;
                    cnt_d     = '0;
                    len_d     = cfg_len;
                    state_d   = RUN;
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    lane_clear = 1'b1;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end else if (accept && (cnt_q == len_q)) begin
                    lane_clear = 1'b1;
                    cnt_d      = '0;
                    state_d    = DONE;
                    done_d     = 1'b1;
                end else begin
                    if (accept) begin
                        lane_advance = 1'b1;
                        cnt_d        = cnt_q + LENW'(1);
                    end
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // One pattern register per channel; each latches its own slice of the
    // configuration on load so later cfg changes do not disturb the burst.
    for (genvar c = 0; c < NCH; c++) begin : g_lane
        nv_blkbox_src_lane #(
            .DW        (DW),
            .LFSR_TAPS (LFSR_TAPS)
        ) u_lane (
            .clk     (nvdla_core_clk),
            .rst     (nvdla_core_rst),
            .clear   (lane_clear),
            .load    (lane_load),
            .advance (lane_advance),
            .mode    (src_mode_e'(cfg_mode[2*c+1:2*c])),
            .seed    (cfg_value[DW*c +: DW]),
            .value   (lane_dout[DW*c +: DW])
        );
    end

    assign src.dout       = lane_dout;
    assign src.dout_valid = valid_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_nv_blkbox_src_gen.sv
// ----------------------------------------------------------------------------
// tb_nv_blkbox_src_gen
// Scoreboard bench for nv_blkbox_src_gen at DW=8, NCH=4, LENW=8. Expected
// beats are queued when a burst is launched and popped as the DUT hands
// beats over (dout_valid & dout_ready sampled on the falling edge).
// ----------------------------------------------------------------------------
module tb_nv_blkbox_src_gen;
    import nv_blkbox_src_pkg::*;

    localparam int DW   = 8;
    localparam int NCH  = 4;
    localparam int LENW = 8;

    logic                 nvdla_core_clk = 1'b0;
    logic                 nvdla_core_rst;
    logic [NCH*2-1:0]     cfg_mode;
    logic [NCH*DW-1:0]    cfg_value;
    logic [LENW-1:0]      cfg_len;
    logic                 start;
    logic                 abort;
    logic                 ready;
    logic                 busy;
    logic                 done;

    int                   checks   = 0;
    int                   failures = 0;
    logic [NCH*DW-1:0]    exp_q[$];

    nv_blkbox_src_gen_if #(.DW(DW), .NCH(NCH)) src_if ();

    assign src_if.dout_ready = ready;

    nv_blkbox_src_gen #(
        .DW   (DW),
        .NCH  (NCH),
        .LENW (LENW)
    ) dut (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .cfg_mode       (cfg_mode),
        .cfg_value      (cfg_value),
        .cfg_len        (cfg_len),
        .start          (start),
        .abort          (abort),
        .src            (src_if),
        .busy           (busy),
        .done           (done)
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    // Reference for beat k of one lane, written in closed form where possible.
    function automatic logic [7:0] model_lane(input logic [1:0] m, input logic [7:0] v, input int k);
        logic [7:0] s;
        int         pos;
        case (m)
            2'd0: return v;
            2'd1: return v + 8'(k);
            2'd2: begin
                s = (v == 8'h00) ? 8'h01 : v;
                for (int i = 0; i < k; i++) s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
                return s;
            end
            default: begin
                pos = ((int'(v) % 8) + k) % 8;
                return 8'(1) << pos;
            end
        endcase
    endfunction

    function automatic logic [31:0] model_word(input logic [7:0] m, input logic [31:0] v, input int k);
        logic [31:0] w;
        w = '0;
        for (int c = 0; c < NCH; c++) w[8*c +: 8] = model_lane(m[2*c +: 2], v[8*c +: 8], k);
        return w;
    endfunction

    // Pulse start for one cycle, then scramble cfg to show it is not re-read.
    task automatic issue_start(input logic [7:0] m, input logic [31:0] v, input logic [7:0] len);
        @(negedge nvdla_core_clk);
        cfg_mode  = m;
        cfg_value = v;
        cfg_len   = len;
        start     = 1'b1;
        @(negedge nvdla_core_clk);
        start     = 1'b0;
        cfg_mode  = 8'($urandom);
        cfg_value = $urandom;
        cfg_len   = 8'($urandom);
    endtask

    task automatic test_reset();
        nvdla_core_rst = 1'b1;
        start = 1'b0; abort = 1'b0; ready = 1'b0;
        cfg_mode = '0; cfg_value = '0; cfg_len = '0;
        repeat (3) @(negedge nvdla_core_clk);
        checks++;
        if ({src_if.dout, src_if.dout_valid, busy, done} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_state got dout=%h valid=%b busy=%b done=%b exp all 0",
                     src_if.dout, src_if.dout_valid, busy, done);
        end
        nvdla_core_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge nvdla_core_clk);
            checks++;
            if ({src_if.dout, src_if.dout_valid, busy, done} !== '0) begin
                failures++;
                $display("[TB] FAIL idle_zero cyc=%0d got dout=%h valid=%b busy=%b done=%b exp all 0",
                         i, src_if.dout, src_if.dout_valid, busy, done);
            end
        end
    endtask

    task automatic test_basic_burst();
        int beats = 0, last_cyc = -1, done_cyc = -1;
        logic [31:0] e;
        exp_q.delete();
        exp_q.push_back(32'h8001FEA5);
        exp_q.push_back(32'h01B8FFA5);
        exp_q.push_back(32'h025C00A5);
        exp_q.push_back(32'h042E01A5);
        ready = 1'b1;
        issue_start(8'hE4, 32'h0700FEA5, 8'd3);
        checks++;
        if (src_if.dout_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL start_latency got valid=%b busy=%b exp 1 1", src_if.dout_valid, busy);
        end
        for (int cyc = 0; cyc < 30 && done_cyc < 0; cyc++) begin
            if (src_if.dout_valid && ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
                checks++;
                if (src_if.dout !== e) begin
                    failures++;
                    $display("[TB] FAIL basic_beat%0d got=%h exp=%h", beats, src_if.dout, e);
                end
                beats++;
                last_cyc = cyc;
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                checks++;
                if ({src_if.dout, src_if.dout_valid, busy} !== '0) begin
                    failures++;
                    $display("[TB] FAIL done_outputs got dout=%h valid=%b busy=%b exp 0 0 0",
                             src_if.dout, src_if.dout_valid, busy);
                end
            end
            @(negedge nvdla_core_clk);
        end
        checks++;
        if (beats !== 4) begin
            failures++;
            $display("[TB] FAIL basic_beat_count got=%0d exp=4", beats);
        end
        checks++;
        if (done_cyc < 0 || done_cyc !== last_cyc + 1) begin
            failures++;
            $display("[TB] FAIL basic_done_timing got=%0d exp=%0d", done_cyc, last_cyc + 1);
        end
        checks++;
        if ({done, src_if.dout_valid, busy} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL after_done got done=%b valid=%b busy=%b exp 0 0 0", done, src_if.dout_valid, busy);
        end
    endtask

    task automatic test_stall();
        int beats = 0, last_cyc = -1, done_cyc = -1;
        logic        stalled = 1'b0;
        logic [31:0] held = '0;
        logic [31:0] e;
        exp_q.delete();
        exp_q.push_back(32'h8001FEA5);
        exp_q.push_back(32'h01B8FFA5);
        exp_q.push_back(32'h025C00A5);
        exp_q.push_back(32'h042E01A5);
        ready = 1'b1;
        issue_start(8'hE4, 32'h0700FEA5, 8'd3);
        for (int cyc = 0; cyc < 40 && done_cyc < 0; cyc++) begin
            ready = (cyc % 3 == 0);
            if (stalled && src_if.dout_valid) begin
                checks++;
                if (src_if.dout !== held) begin
                    failures++;
                    $display("[TB] FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, src_if.dout, held);
                end
            end
            stalled = src_if.dout_valid && !ready;
            held    = src_if.dout;
            if (src_if.dout_valid && ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
                checks++;
                if (src_if.dout !== e) begin
                    failures++;
                    $display("[TB] FAIL stall_beat%0d got=%h exp=%h", beats, src_if.dout, e);
                end
                beats++;
                last_cyc = cyc;
            end
            if (done === 1'b1) done_cyc = cyc;
            @(negedge nvdla_core_clk);
        end
        ready = 1'b1;
        checks++;
        if (beats !== 4 || done_cyc < 0 || done_cyc !== last_cyc + 1) begin
            failures++;
            $display("[TB] FAIL stall_completion got beats=%0d done_cyc=%0d exp beats=4 done_cyc=%0d",
                     beats, done_cyc, last_cyc + 1);
        end
    endtask

    task automatic test_abort();
        int beats = 0;
        logic aborted = 1'b0;
        logic seen = 1'b0;
        logic [7:0]  m = 8'($urandom);
        logic [31:0] v = $urandom;
        logic [31:0] e;
        exp_q.delete();
        for (int k = 0; k < 3; k++) exp_q.push_back(model_word(m, v, k));
        ready = 1'b1;
        issue_start(m, v, 8'd5);
        for (int cyc = 0; cyc < 20 && !aborted; cyc++) begin
            abort = (beats == 2) && src_if.dout_valid;
            if (src_if.dout_valid && ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
                checks++;
                if (src_if.dout !== e) begin
                    failures++;
                    $display("[TB] FAIL abort_beat%0d got=%h exp=%h", beats, src_if.dout, e);
                end
                beats++;
            end
            aborted = abort;
            @(negedge nvdla_core_clk);
        end
        abort = 1'b0;
        checks++;
        if (!aborted || {src_if.dout, src_if.dout_valid, busy, done} !== '0) begin
            failures++;
            $display("[TB] FAIL abort_idle got dout=%h valid=%b busy=%b done=%b exp all 0",
                     src_if.dout, src_if.dout_valid, busy, done);
        end
        for (int i = 0; i < 6; i++) begin
            if (done || src_if.dout_valid) seen = 1'b1;
            @(negedge nvdla_core_clk);
        end
        checks++;
        if (beats !== 3 || seen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_no_done got beats=%0d stray=%b exp beats=3 stray=0", beats, seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v = $urandom;
        logic [31:0] e;
        exp_q.delete();
        exp_q.push_back(model_word(8'h1B, v, 0));
        exp_q.push_back(model_word(8'h1B, v, 0));
        ready = 1'b1;
        @(negedge nvdla_core_clk);
        cfg_mode = 8'h1B; cfg_value = v; cfg_len = 8'd0; start = 1'b1;
        @(negedge nvdla_core_clk);
        e = exp_q.pop_front();
        checks++;
        if (src_if.dout_valid !== 1'b1 || busy !== 1'b1 || src_if.dout !== e) begin
            failures++;
            $display("[TB] FAIL b2b_first got valid=%b busy=%b dout=%h exp 1 1 %h", src_if.dout_valid, busy, src_if.dout, e);
        end
        @(negedge nvdla_core_clk);
        checks++;
        if (done !== 1'b1 || src_if.dout_valid !== 1'b0 || busy !== 1'b0 || src_if.dout !== '0) begin
            failures++;
            $display("[TB] FAIL b2b_done got done=%b valid=%b busy=%b dout=%h exp 1 0 0 0", done, src_if.dout_valid, busy, src_if.dout);
        end
        @(negedge nvdla_core_clk);
        checks++;
        if ({done, src_if.dout_valid, busy} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL b2b_gap got done=%b valid=%b busy=%b exp 0 0 0", done, src_if.dout_valid, busy);
        end
        @(negedge nvdla_core_clk);
        e = exp_q.pop_front();
        checks++;
        if (src_if.dout_valid !== 1'b1 || busy !== 1'b1 || src_if.dout !== e) begin
            failures++;
            $display("[TB] FAIL b2b_second got valid=%b busy=%b dout=%h exp 1 1 %h", src_if.dout_valid, busy, src_if.dout, e);
        end
        start = 1'b0;
        @(negedge nvdla_core_clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_second_done got=%b exp=1", done);
        end
        @(negedge nvdla_core_clk);
    endtask

    task automatic test_random_bursts();
        for (int b = 0; b < 4; b++) begin
            int beats = 0, done_cyc = -1;
            logic [7:0]  m   = 8'($urandom);
            logic [31:0] v   = $urandom;
            logic [7:0]  len = 8'($urandom_range(0, 6));
            logic [31:0] e;
            exp_q.delete();
            for (int k = 0; k <= int'(len); k++) exp_q.push_back(model_word(m, v, k));
            ready = 1'b1;
            issue_start(m, v, len);
            for (int cyc = 0; cyc < 200 && done_cyc < 0; cyc++) begin
                ready = ($urandom_range(0, 9) < 7);
                if (src_if.dout_valid && ready) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
                    checks++;
                    if (src_if.dout !== e) begin
                        failures++;
                        $display("[TB] FAIL rand%0d_beat%0d got=%h exp=%h", b, beats, src_if.dout, e);
                    end
                    beats++;
                end
                if (done === 1'b1) done_cyc = cyc;
                @(negedge nvdla_core_clk);
            end
            checks++;
            if (beats !== int'(len) + 1 || done_cyc < 0) begin
                failures++;
                $display("[TB] FAIL rand%0d_count got beats=%0d done=%0d exp beats=%0d done>=0", b, beats, done_cyc, int'(len) + 1);
            end
        end
        ready = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        logic seen = 1'b0;
        exp_q.delete();
        ready = 1'b1;
        issue_start(8'hE4, $urandom, 8'd10);
        repeat (3) @(negedge nvdla_core_clk);
        nvdla_core_rst = 1'b1;
        @(negedge nvdla_core_clk);
        checks++;
        if ({src_if.dout, src_if.dout_valid, busy, done} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mid_run got dout=%h valid=%b busy=%b done=%b exp all 0",
                     src_if.dout, src_if.dout_valid, busy, done);
        end
        nvdla_core_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge nvdla_core_clk);
            if (done || src_if.dout_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_no_resume got stray=%b exp=0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_stall();
        test_abort();
        test_back_to_back();
        test_random_bursts();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
